conv_addr_sched: RTL

Sequencing controller for the convolution input-feature address generator and its MAC datapath. Accepts a layer start command, resets the address generator, and gates its `enable` cycle by cycle under a downstream hold. It tags each read beat with first/last-of-window flags aligned to memory data. It reports completion with a start/busy/done handshake, so one generator and MAC array can run layer after layer without software touching the counters.

---
 rtl/conv_addr_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/conv_addr_sched.sv
// Layer sequencer for the convolution address generator and MAC array.
// Optional macro SCHED_BANK_SWAP_EN: ping-pong output bank toggled at every layer end.
module conv_addr_sched #(
  parameter int BEATS_PER_WIN = 26,
  parameter int NUM_WIN       = 144,
  parameter int NUM_PASS      = 1,
  parameter int PIPE_LAT      = 2,
  parameter int BEAT_W        = 5,
  parameter int WIN_W         = 8,
  parameter int PASS_W        = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              gen_reset,
  output logic              gen_enable,
  output logic              data_valid,
  output logic              acc_first,
  output logic              acc_last,
  output logic [WIN_W-1:0]  win_idx,
  output logic [PASS_W-1:0] pass_idx,
  output logic              bank_sel
);

  localparam int TAG_W = 3 + WIN_W + PASS_W;
  localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BEATS_PER_WIN - 1);
  localparam logic [WIN_W-1:0]  WIN_MAX  = WIN_W'(NUM_WIN - 1);
  localparam logic [PASS_W-1:0] PASS_MAX = PASS_W'(NUM_PASS - 1);
  localparam logic [DRN_W-1:0]  DRN_MAX  = DRN_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [PASS_W-1:0]  pass_q, pass_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic [TAG_W-1:0]   pipe_q [PIPE_LAT];
  logic               issue_s;
  logic [TAG_W-1:0]   tag_s;
  logic [TAG_W-1:0]   tail_s;

  assign issue_s = (state_q == S_RUN) && !hold;

  // Invalid entries carry all-zero fields so idle outputs stay low.
  assign tag_s = issue_s ? {1'b1, (beat_q == {BEAT_W{1'b0}}), (beat_q == BEAT_MAX), win_q, pass_q}
                         : {TAG_W{1'b0}};

  // Next-state and counter update logic.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    win_d   = win_q;
    pass_d  = pass_q;
    drn_d   = drn_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
        else       state_d = S_IDLE;
      end
      S_CLEAR: begin
        beat_d  = {BEAT_W{1'b0}};
        win_d   = {WIN_W{1'b0}};
        pass_d  = {PASS_W{1'b0}};
        drn_d   = {DRN_W{1'b0}};
        state_d = S_RUN;
      end
      S_RUN: begin
        if (!hold) begin
          if (beat_q == BEAT_MAX) begin
            beat_d = {BEAT_W{1'b0}};
            if (win_q == WIN_MAX) begin
              win_d = {WIN_W{1'b0}};
              if (pass_q == PASS_MAX) begin
                pass_d  = {PASS_W{1'b0}};
                state_d = S_DRAIN;
              end else begin
                pass_d = pass_q + PASS_W'(1);
              end
            end else begin
              win_d = win_q + WIN_W'(1);
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_MAX) begin
          drn_d   = {DRN_W{1'b0}};
          state_d = S_DONE;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= {BEAT_W{1'b0}};
      win_q   <= {WIN_W{1'b0}};
      pass_q  <= {PASS_W{1'b0}};
      drn_q   <= {DRN_W{1'b0}};
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      win_q   <= win_d;
      pass_q  <= pass_d;
      drn_q   <= drn_d;
    end
  end

  // Tag delay line matching generator + memory read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= {TAG_W{1'b0}};
    end else begin
      pipe_q[0] <= tag_s;
      for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail_s     = pipe_q[PIPE_LAT-1];
  assign data_valid = tail_s[TAG_W-1];
  assign acc_first  = tail_s[TAG_W-2];
  assign acc_last   = tail_s[TAG_W-3];
  assign win_idx    = tail_s[PASS_W +: WIN_W];
  assign pass_idx   = tail_s[PASS_W-1:0];

  assign busy       = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign gen_reset  = (state_q == S_CLEAR);
  assign gen_enable = issue_s;

`ifdef SCHED_BANK_SWAP_EN
  logic bank_q, bank_d;

  // Flip the output bank on each completed layer.
  always_comb begin
    if (state_q == S_DONE) bank_d = ~bank_q;
    else                   bank_d = bank_q;
  end

  // Bank select register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bank_q <= 1'b0;
    else       bank_q <= bank_d;
  end

  assign bank_sel = bank_q;
`else
  assign bank_sel = 1'b0;
`endif

endmodule
